// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory bus arbiter between IMEM fetch and DMEM load/store
//
// Purpose:
//   Shares one unified memory bus between the core's instruction fetch port
//   and its load/store port. Only one bus transaction is outstanding at a
//   time. Returned data is held on the port outputs until the whole pipeline
//   advances (a clock edge with stall_o low). A single global stall goes to
//   the hazard unit.
//
// Optional feature:
//   MEM_ARB_PERF_EN - adds saturating performance counters perf_stall_cyc_o
//   (cycles with stall_o high) and perf_conflict_o (IDLE cycles in which both
//   ports are pending).
//
// Parameters:
//   DMEM_PRIO  1: DMEM wins simultaneous new requests, 0: IMEM wins
//   ADDR_W     bus address width
//
// Ports:
//   clk            core clock
//   rst_i          synchronous active-low reset
//   imem_rd_en_i   fetch request (level)
//   imem_addr_i    fetch address
//   imem_data_o    fetched instruction (held)
//   dmem_rd_en_i   load request (level)
//   dmem_wr_en_i   store request (level)
//   dmem_addr_i    load/store address
//   dmem_data_i    store data
//   dmem_size_i    access size (byte/half/word)
//   dmem_data_o    load data (held)
//   stall_o        global pipeline stall
//   mem_req_o      bus request
//   mem_we_o       bus write
//   mem_addr_o     bus address
//   mem_wdata_o    bus write data
//   mem_size_o     bus size (2'b10 for fetches)
//   mem_gnt_i      bus accepted the request this cycle
//   mem_rvalid_i   bus response (read data or write ack)
//   mem_rdata_i    bus read data
//   perf_stall_cyc_o, perf_conflict_o  (MEM_ARB_PERF_EN only)

module mem_arbiter #(
  parameter bit DMEM_PRIO = 1'b1,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              imem_rd_en_i,
  input  logic [ADDR_W-1:0] imem_addr_i,
  output logic [31:0]       imem_data_o,
  input  logic              dmem_rd_en_i,
  input  logic              dmem_wr_en_i,
  input  logic [ADDR_W-1:0] dmem_addr_i,
  input  logic [31:0]       dmem_data_i,
  input  logic [1:0]        dmem_size_i,
  output logic [31:0]       dmem_data_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [1:0]        mem_size_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_stall_cyc_o,
  output logic [31:0]       perf_conflict_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_d_q, owner_d_d;   // 1: DMEM owns the bus transaction
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic [31:0]       imem_data_q, imem_data_d;
  logic [31:0]       dmem_data_q, dmem_data_d;

  logic i_pend;
  logic d_pend;
  logic stall;

  // A port is pending until its result has been delivered; the done flag
  // masks a still-asserted request until the pipeline actually advances.
  assign i_pend = imem_rd_en_i && !i_done_q;
  assign d_pend = (dmem_rd_en_i || dmem_wr_en_i) && !d_done_q;
  assign stall  = i_pend || d_pend;

  always_comb begin
    state_d     = state_q;
    owner_d_d   = owner_d_q;
    i_done_d    = i_done_q;
    d_done_d    = d_done_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;
    imem_data_d = imem_data_q;
    dmem_data_d = dmem_data_q;

    // Pipeline advanced: every request seen from now on is a new one.
    if (!stall) begin
      i_done_d = 1'b0;
      d_done_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (d_pend && (DMEM_PRIO || !i_pend)) begin
          state_d     = ST_REQ;
          owner_d_d   = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = dmem_wr_en_i;
          mem_addr_d  = dmem_addr_i;
          mem_wdata_d = dmem_data_i;
          mem_size_d  = dmem_size_i;
        end else if (i_pend) begin
          state_d     = ST_REQ;
          owner_d_d   = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = imem_addr_i;
          mem_wdata_d = 32'd0;
          mem_size_d  = 2'b10;
        end
      end

      ST_REQ: begin
        // Bus fields stay frozen until the slave accepts.
        if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          state_d   = ST_RSP;
        end
      end

      ST_RSP: begin
        if (mem_rvalid_i) begin
          state_d = ST_IDLE;
          // A done flag set here wins over the advance-clear above; a
          // squashed request's flag then drops at the next low-stall edge.
          if (owner_d_q) begin
            d_done_d = 1'b1;
            if (!mem_we_q) begin
              dmem_data_d = mem_rdata_i;
            end
          end else begin
            i_done_d    = 1'b1;
            imem_data_d = mem_rdata_i;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      owner_d_q   <= 1'b0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      mem_size_q  <= 2'b00;
      imem_data_q <= 32'd0;
      dmem_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      owner_d_q   <= owner_d_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
      imem_data_q <= imem_data_d;
      dmem_data_q <= dmem_data_d;
    end
  end

  assign stall_o     = stall;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_size_o  = mem_size_q;
  assign imem_data_o = imem_data_q;
  assign dmem_data_o = dmem_data_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_stall_cyc_q, perf_stall_cyc_d;
  logic [31:0] perf_conflict_q, perf_conflict_d;

  always_comb begin
    perf_stall_cyc_d = perf_stall_cyc_q;
    perf_conflict_d  = perf_conflict_q;
    if (stall && (perf_stall_cyc_q != 32'hFFFF_FFFF)) begin
      perf_stall_cyc_d = perf_stall_cyc_q + 32'd1;
    end
    if ((state_q == ST_IDLE) && i_pend && d_pend &&
        (perf_conflict_q != 32'hFFFF_FFFF)) begin
      perf_conflict_d = perf_conflict_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      perf_stall_cyc_q <= 32'd0;
      perf_conflict_q  <= 32'd0;
    end else begin
      perf_stall_cyc_q <= perf_stall_cyc_d;
      perf_conflict_q  <= perf_conflict_d;
    end
  end

  assign perf_stall_cyc_o = perf_stall_cyc_q;
  assign perf_conflict_o  = perf_conflict_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter

module tb_mem_arbiter;

  localparam bit DMEM_PRIO = 1'b1;
  localparam int ADDR_W    = 32;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              imem_rd_en_i;
  logic [ADDR_W-1:0] imem_addr_i;
  logic [31:0]       imem_data_o;
  logic              dmem_rd_en_i;
  logic              dmem_wr_en_i;
  logic [ADDR_W-1:0] dmem_addr_i;
  logic [31:0]       dmem_data_i;
  logic [1:0]        dmem_size_i;
  logic [31:0]       dmem_data_o;
  logic              stall_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [1:0]        mem_size_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [31:0]       mem_rdata_i;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]       perf_stall_cyc_o;
  logic [31:0]       perf_conflict_o;
`endif

  mem_arbiter #(.DMEM_PRIO(DMEM_PRIO), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .imem_rd_en_i (imem_rd_en_i),
    .imem_addr_i  (imem_addr_i),
    .imem_data_o  (imem_data_o),
    .dmem_rd_en_i (dmem_rd_en_i),
    .dmem_wr_en_i (dmem_wr_en_i),
    .dmem_addr_i  (dmem_addr_i),
    .dmem_data_i  (dmem_data_i),
    .dmem_size_i  (dmem_size_i),
    .dmem_data_o  (dmem_data_o),
    .stall_o      (stall_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_size_o   (mem_size_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_stall_cyc_o (perf_stall_cyc_o),
    .perf_conflict_o  (perf_conflict_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    int          gd;
    int          rd;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        cur;
  bit          rsp_active;
  int          rcnt;
  int          gcnt;
  bit          stray_en;
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];
  logic [31:0] last_dload;
  int          last_stall;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    slave_mem[a] = v;
    ref_mem[a]   = v;
  endtask

  // Bus slave: grants after the transaction's gd extra REQ cycles, responds
  // rd cycles after the grant, and optionally toggles stray handshakes where
  // the arbiter must ignore them.
  task automatic slave_step();
    txn_t t;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = $urandom;
    if (rsp_active) begin
      rcnt--;
      if (rcnt == 0) begin
        mem_rvalid_i = 1'b1;
        if (cur.we) slave_mem[cur.addr] = cur.wdata;
        else        mem_rdata_i = slave_rd(cur.addr);
        rsp_active = 1'b0;
      end else if (stray_en && ($urandom_range(0, 3) == 0)) begin
        mem_gnt_i = 1'b1;
      end
    end else if (mem_req_o) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_req", 64'd1, 64'd0);
      end else begin
        t = exp_q[0];
        check_eq("req_addr", mem_addr_o, t.addr);
        check_eq("req_we", mem_we_o, t.we);
        check_eq("req_size", mem_size_o, t.size);
        if (t.we) check_eq("req_wdata", mem_wdata_o, t.wdata);
        if (gcnt == t.gd) begin
          mem_gnt_i  = 1'b1;
          cur        = exp_q.pop_front();
          rsp_active = 1'b1;
          rcnt       = cur.rd;
          gcnt       = 0;
        end else begin
          gcnt++;
          if (stray_en && ($urandom_range(0, 3) == 0)) mem_rvalid_i = 1'b1;
        end
      end
    end else if (stray_en && ($urandom_range(0, 3) == 0)) begin
      mem_gnt_i    = 1'($urandom_range(0, 1));
      mem_rvalid_i = 1'b1;
    end
  endtask

  task automatic drive_cycle(input bit i_rd, input logic [31:0] i_a, input bit d_rd,
                             input bit d_wr, input logic [31:0] d_a,
                             input logic [31:0] d_w, input logic [1:0] d_s);
    @(negedge clk);
    imem_rd_en_i = i_rd;
    imem_addr_i  = i_a;
    dmem_rd_en_i = d_rd;
    dmem_wr_en_i = d_wr;
    dmem_addr_i  = d_a;
    dmem_data_i  = d_w;
    dmem_size_i  = d_s;
    slave_step();
    #1;
  endtask

  task automatic push_txn(input bit is_d, input bit we, input logic [31:0] a,
                          input logic [31:0] w, input logic [1:0] s, input int gd, input int rd);
    txn_t t;
    t.is_d = is_d; t.we = we; t.addr = a; t.wdata = w; t.size = s; t.gd = gd; t.rd = rd;
    exp_q.push_back(t);
  endtask

  // One pipeline step: hold the requests until stall_o drops, then check the
  // stall length (each transaction costs one IDLE cycle, gd+1 REQ cycles and
  // rd RSP cycles) and the delivered data.
  task automatic run_step(input bit ireq, input logic [31:0] iaddr, input bit dreq,
                          input bit dwr, input logic [31:0] daddr, input logic [31:0] wdata,
                          input logic [1:0] size, input int gd_i, input int rd_i,
                          input int gd_d, input int rd_d);
    int          exp_stall = 0;
    int          cnt = 0;
    bit          done = 1'b0;
    bit          d_first;
    logic [31:0] exp_i;
    logic [31:0] exp_d;
    d_first = dreq && (DMEM_PRIO || !ireq);
    if (d_first) push_txn(1'b1, dwr, daddr, wdata, size, gd_d, rd_d);
    if (ireq)    push_txn(1'b0, 1'b0, iaddr, 32'd0, 2'b10, gd_i, rd_i);
    if (dreq && !d_first) push_txn(1'b1, dwr, daddr, wdata, size, gd_d, rd_d);
    if (ireq) exp_stall += 2 + gd_i + rd_i;
    if (dreq) exp_stall += 2 + gd_d + rd_d;
    exp_i = ref_rd(iaddr);
    exp_d = ref_rd(daddr);
    for (int c = 0; c < 200 && !done; c++) begin
      drive_cycle(ireq, iaddr, dreq && !dwr, dreq && dwr, daddr, wdata, size);
      if (stall_o) cnt++;
      else         done = 1'b1;
    end
    last_stall = cnt;
    if (!done) check_eq("step_timeout", 64'd0, 64'd1);
    check_eq("stall_cyc", 64'(cnt), 64'(exp_stall));
    check_eq("bus_drained", 64'(exp_q.size()), 64'd0);
    if (ireq) check_eq("imem_data", imem_data_o, exp_i);
    if (dreq && !dwr) begin
      check_eq("dmem_load", dmem_data_o, exp_d);
      last_dload = exp_d;
    end else begin
      check_eq("dmem_hold", dmem_data_o, last_dload);
    end
    if (dreq && dwr) ref_mem[daddr] = wdata;
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sq_stall;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] p_stall0;
    logic [31:0] p_conf0;
`endif
    rsp_active = 1'b0;
    rcnt       = 0;
    gcnt       = 0;
    stray_en   = 1'b0;
    last_dload = 32'd0;
    last_stall = 0;

    // Reset with the bus and both ports busy.
    rst_i        = 1'b0;
    imem_rd_en_i = 1'b1;
    imem_addr_i  = 32'h0000_0100;
    dmem_rd_en_i = 1'b0;
    dmem_wr_en_i = 1'b1;
    dmem_addr_i  = 32'h0000_1100;
    dmem_data_i  = 32'h1111_2222;
    dmem_size_i  = 2'b01;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_req", mem_req_o, 1'b0);
    check_eq("rst_we", mem_we_o, 1'b0);
    check_eq("rst_addr", mem_addr_o, 32'd0);
    check_eq("rst_wdata", mem_wdata_o, 32'd0);
    check_eq("rst_size", mem_size_o, 2'b00);
    check_eq("rst_imem", imem_data_o, 32'd0);
    check_eq("rst_dmem", dmem_data_o, 32'd0);
    check_eq("rst_stall", stall_o, 1'b1);
`ifdef MEM_ARB_PERF_EN
    check_eq("rst_perf_stall", perf_stall_cyc_o, 32'd0);
    check_eq("rst_perf_conf", perf_conflict_o, 32'd0);
`endif
    // Release with a stray response that must be ignored in IDLE.
    rst_i        = 1'b1;
    imem_rd_en_i = 1'b0;
    dmem_wr_en_i = 1'b0;
    mem_gnt_i    = 1'b0;
    #1;
    check_eq("post_rst_stall", stall_o, 1'b0);
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    #1;
    check_eq("stray_imem", imem_data_o, 32'd0);
    check_eq("stray_req", mem_req_o, 1'b0);

    // Single fetch, grant in first REQ cycle, response one cycle later.
    preload(32'h0000_0040, 32'h0010_0093);
    run_step(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_1000, 32'd0, 2'b10, 0, 1, 0, 1);

    // Simultaneous fetch and load: DMEM goes first, one shared release.
    preload(32'h0000_0044, 32'h0020_0113);
    preload(32'h0000_1000, 32'h1234_5678);
`ifdef MEM_ARB_PERF_EN
    p_stall0 = perf_stall_cyc_o;
    p_conf0  = perf_conflict_o;
`endif
    run_step(1'b1, 32'h0000_0044, 1'b1, 1'b0, 32'h0000_1000, 32'd0, 2'b10, 0, 1, 0, 1);
`ifdef MEM_ARB_PERF_EN
    check_eq("perf_conflict", perf_conflict_o - p_conf0, 32'd1);
    check_eq("perf_stall", perf_stall_cyc_o - p_stall0, 32'(last_stall));
`endif

    // Store with the grant held off for four REQ cycles.
    run_step(1'b0, 32'h0000_0048, 1'b1, 1'b1, 32'h0000_2000, 32'hCAFE_F00D, 2'b00, 0, 1, 3, 2);
    check_eq("store_mem", slave_rd(32'h0000_2000), 32'hCAFE_F00D);

    // Back-to-back fetches of one address held across the release cycle:
    // the second must re-fetch and see the new contents.
    preload(32'h0000_0050, 32'h0000_0013);
    run_step(1'b1, 32'h0000_0050, 1'b0, 1'b0, 32'h0000_1004, 32'd0, 2'b10, 1, 1, 0, 1);
    preload(32'h0000_0050, 32'h0040_0193);
    run_step(1'b1, 32'h0000_0050, 1'b0, 1'b0, 32'h0000_1004, 32'd0, 2'b10, 0, 2, 0, 1);

    // Squash: fetch dropped after issue; stall releases at once while the bus
    // transaction still completes.
    push_txn(1'b0, 1'b0, 32'h0000_0080, 32'd0, 2'b10, 2, 2);
    drive_cycle(1'b1, 32'h0000_0080, 1'b0, 1'b0, 32'h0000_1000, 32'd0, 2'b10);
    check_eq("squash_issue_stall", stall_o, 1'b1);
    sq_stall = 0;
    for (int c = 0; c < 10; c++) begin
      drive_cycle(1'b0, 32'h0000_0080, 1'b0, 1'b0, 32'h0000_1000, 32'd0, 2'b10);
      if (stall_o) sq_stall++;
    end
    check_eq("squash_stall", 64'(sq_stall), 64'd0);
    check_eq("squash_drained", 64'(exp_q.size()), 64'd0);
    check_eq("squash_rsp_done", rsp_active, 1'b0);
    exp_q.delete();
    preload(32'h0000_0080, 32'h00A0_0513);
    run_step(1'b1, 32'h0000_0080, 1'b0, 1'b0, 32'h0000_1000, 32'd0, 2'b10, 1, 1, 0, 1);

    // Randomized traffic with stray handshakes.
    stray_en = 1'b1;
    for (int s = 0; s < 250; s++) begin
      bit          ireq;
      bit          dreq;
      bit          dwr;
      logic [31:0] ia;
      logic [31:0] da;
      ireq = ($urandom_range(0, 3) != 0);
      dreq = ($urandom_range(0, 2) == 0) || (s % 7 == 0);
      dwr  = ($urandom_range(0, 2) == 0);
      ia   = 32'($urandom_range(0, 255)) << 2;
      da   = 32'h0000_1000 + (32'($urandom_range(0, 63)) << 2);
      run_step(ireq, ia, dreq, dwr, da, $urandom, 2'($urandom_range(0, 2)),
               int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory bus between the core's IMEM fetch port and DMEM load/store port.
- Sequences one outstanding bus transaction at a time.
- Holds returned data until the whole pipeline advances.
- Drives one global stall to the hazard unit. Sits between core_riscv memory ports and the memory/bus slave.

Parameters:
- DMEM_PRIO, 1, 1: DMEM wins simultaneous new requests (older instruction). 0: IMEM wins.
- ADDR_W, 32, bus address width.

Ports:
- clk  in  1  core clock
- rst_i  in  1  synchronous, active-low reset
- imem_rd_en_i  in  1  fetch request (level)
- imem_addr_i  in  ADDR_W  fetch address
- imem_data_o  out  32  fetched instruction (held)
- dmem_rd_en_i  in  1  load request (level)
- dmem_wr_en_i  in  1  store request (level)
- dmem_addr_i  in  ADDR_W  load/store address
- dmem_data_i  in  32  store data
- dmem_size_i  in  2  byte/half/word
- dmem_data_o  out  32  load data (held)
- stall_o  out  1  global pipeline stall
- mem_req_o  out  1  bus request
- mem_we_o  out  1  bus write
- mem_addr_o  out  ADDR_W  bus address
- mem_wdata_o  out  32  bus write data
- mem_size_o  out  2  bus size; 2'b10 for IMEM
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  response (read data or write ack)
- mem_rdata_i  in  32  read data

Behaviour:
- Reset (rst_i==0 at posedge): FSM→IDLE. Clear i_done and d_done. Drive mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_size_o=0 and imem_data_o/dmem_data_o=0.
- Reset mid-transaction abandons it. mem_rvalid_i received in IDLE is ignored.
- i_pend = imem_rd_en_i && !i_done. d_pend = (dmem_rd_en_i || dmem_wr_en_i) && !d_done.
- stall_o = i_pend || d_pend (combinational). During reset stall_o follows the same equation with cleared flags.
- FSM states: IDLE, REQ (mem_req_o high, awaiting gnt), RSP (awaiting rvalid).
- IDLE: if d_pend && (DMEM_PRIO || !i_pend), latch the DMEM transaction, register bus fields, go to REQ, owner=D. Else if i_pend, latch IMEM (we=0, size=2'b10), go to REQ, owner=I. Else stay.
- REQ: mem_req_o and all bus fields held stable until mem_gnt_i. On gnt, drop mem_req_o at next edge and go to RSP.
- RSP: on mem_rvalid_i, set the owner's done flag. For a read, capture mem_rdata_i into imem_data_o/dmem_data_o. A store leaves dmem_data_o unchanged. Go to IDLE.
- Done flags clear at a posedge where stall_o==0 (the pipeline advanced). A still-asserted request in the next cycle is a new transaction.
- Done data stays stable while the other port is serviced. Returned data is never lost or re-fetched.
- Uncontended read with gnt in first REQ cycle and rvalid one cycle later: request at cycle 0, REQ in cycle 1, RSP in cycle 2, done at edge 3. stall_o high cycles 0–2, low cycle 3, data valid cycle 3.
- Both requests at once (DMEM_PRIO=1): DMEM first, then IMEM. stall_o stays high until both done. Both outputs valid in the same low-stall cycle.
- Request dropped after issue (e.g. squash): the transaction still completes on the bus and its result is discarded. The done flag clears at the next stall_o==0 edge.
- mem_gnt_i/mem_rvalid_i outside REQ/RSP: ignored.

Optional Feature:
- Macro MEM_ARB_PERF_EN. Defined: adds outputs perf_stall_cyc_o[31:0] (cycles stall_o high) and perf_conflict_o[31:0] (IDLE cycles with i_pend && d_pend both true). Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters absent. Functional behaviour is identical.

Test Plan:
- Reset: hold rst_i=0 three cycles with bus activity → all outputs 0, FSM IDLE. Stray mem_rvalid_i=1 with rdata 32'hDEAD_BEEF after release → imem_data_o stays 0.
- Single fetch addr 32'h0000_0040, gnt same cycle, rvalid next with 32'h0010_0093 → stall_o high 3 cycles. imem_data_o=32'h0010_0093 in the low cycle. mem_size_o=2'b10, mem_we_o=0.
- Simultaneous fetch 32'h44 and load 32'h1000 (rdata 32'h1234_5678), DMEM_PRIO=1 → bus sees 32'h1000 then 32'h44. Single stall_o release with both outputs valid.
- Store 32'h2000 data 32'hCAFE_F00D size 2'b00, gnt delayed 4 cycles → mem fields stable all 4 REQ cycles. mem_we_o=1. dmem_data_o unchanged.
- Back-to-back fetches held high across the release cycle → second fetch starts a new transaction. No stale data reused.
- MEM_ARB_PERF_EN: the simultaneous-request scenario → perf_conflict_o=1. perf_stall_cyc_o equals the measured stall cycles.
